// File: rtl/data_ram_resp_pkg.sv
// Shared types and constants for the data-memory responder.
// Bus widths, FSM state encoding and the write-alignment helper.
package data_ram_resp_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned BE_W   = DATA_W / 8;
    localparam int unsigned CNT_W  = 4;

    localparam logic [ADDR_W-1:0] DATA_RAM_BASE = 32'h0000_0000;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StWait = 2'd1,
        StResp = 2'd2
    } state_e;

    // A write lane group must be a naturally aligned byte, half-word or word
    // whose lowest enabled lane matches the byte offset of the address.
    function automatic logic write_aligned(input logic [BE_W-1:0] be, input logic [1:0] lsb);
        logic       legal;
        logic [1:0] low;
        legal = 1'b1;
        low   = 2'd0;
        case (be)
            4'b0001, 4'b0011, 4'b1111: low = 2'd0;
            4'b0010:                   low = 2'd1;
            4'b0100, 4'b1100:          low = 2'd2;
            4'b1000:                   low = 2'd3;
            default:                   legal = 1'b0;
        endcase
        return legal && (low == lsb);
    endfunction

endpackage

// File: rtl/data_ram_array.sv
// Single-port synchronous RAM, DEPTH_WORDS x 32, with per-byte write enables.
// Read data is registered and only updates on an enabled access.
module data_ram_array #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned IDX_W       = 10
) (
    input  logic             clk,
    input  logic             en,
    input  logic [3:0]       we,
    input  logic [IDX_W-1:0] addr,
    input  logic [31:0]      wdata,
    output logic [31:0]      rdata
);

    logic [31:0] mem [DEPTH_WORDS];
    logic [31:0] rdata_q;

    always_ff @(posedge clk) begin
        if (en) begin
            for (int i = 0; i < 4; i++) begin
                if (we[i]) begin
                    mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (en) begin
            rdata_q <= mem[addr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/data_ram_resp.sv
// Data-memory responder: one request at a time, WAIT_CYCLES wait states, then a response.
// Build macro DATA_RAM_MISALIGN_ERR_EN enables write/read alignment error reporting.
module data_ram_resp
    import data_ram_resp_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = DATA_RAM_BASE,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    input  logic [3:0]  req_be_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_rdata_o,
    output logic        rsp_err_o
);

    localparam int unsigned IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [CNT_W-1:0] WAIT_LOAD =
        (WAIT_CYCLES == 0) ? '0 : CNT_W'(WAIT_CYCLES - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ready_q;
    logic             err_q, err_d;
    logic             zero_q, zero_d;

    logic             lat_we_q;
    logic [31:0]      lat_addr_q;
    logic [31:0]      lat_wdata_q;
    logic [3:0]       lat_be_q;

    logic             accept;
    logic             enter_resp;
    logic             cur_we;
    logic [31:0]      cur_addr;
    logic [31:0]      cur_wdata;
    logic [3:0]       cur_be;
    logic [31:0]      offset;
    logic             in_range;
    logic             wr_misalign;
    logic             rd_misalign;
    logic             ram_en;
    logic [3:0]       ram_we;
    logic [31:0]      ram_rdata;
    logic             unused_offset_lsb;

    assign accept = req_valid_i & ready_q;

    // With zero wait states the access happens on the accept edge itself, so
    // IDLE must present the live request rather than the latched copy.
    always_comb begin
        if (state_q == StIdle) begin
            cur_we    = req_we_i;
            cur_addr  = req_addr_i;
            cur_wdata = req_wdata_i;
            cur_be    = req_be_i;
        end else begin
            cur_we    = lat_we_q;
            cur_addr  = lat_addr_q;
            cur_wdata = lat_wdata_q;
            cur_be    = lat_be_q;
        end
    end

    assign offset            = cur_addr - BASE_ADDR;
    assign in_range          = ({2'b00, offset[31:2]} < DEPTH_WORDS);
    assign unused_offset_lsb = ^offset[1:0];

`ifdef DATA_RAM_MISALIGN_ERR_EN
    assign wr_misalign = cur_we & ~write_aligned(cur_be, cur_addr[1:0]);
    assign rd_misalign = ~cur_we & (cur_addr[1:0] != 2'd0) & (cur_be == 4'b1111);
`else
    assign wr_misalign = 1'b0;
    assign rd_misalign = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        enter_resp = 1'b0;
        case (state_q)
            StIdle: begin
                if (accept) begin
                    if (WAIT_CYCLES == 0) begin
                        state_d    = StResp;
                        enter_resp = 1'b1;
                    end else begin
                        state_d = StWait;
                        cnt_d   = WAIT_LOAD;
                    end
                end
            end
            StWait: begin
                if (cnt_q == '0) begin
                    state_d    = StResp;
                    enter_resp = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StResp: begin
                if (rsp_ready_i) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Response flags are captured with the storage access and then held.
    always_comb begin
        err_d  = err_q;
        zero_d = zero_q;
        if (enter_resp) begin
            err_d  = ~in_range | wr_misalign | rd_misalign;
            zero_d = cur_we | ~in_range;
        end
    end

    assign ram_en = enter_resp & in_range & ~wr_misalign;
    assign ram_we = cur_we ? cur_be : 4'b0000;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            ready_q     <= 1'b0;
            err_q       <= 1'b0;
            zero_q      <= 1'b1;
            lat_we_q    <= 1'b0;
            lat_addr_q  <= '0;
            lat_wdata_q <= '0;
            lat_be_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ready_q <= (state_d == StIdle);
            err_q   <= err_d;
            zero_q  <= zero_d;
            if (accept) begin
                lat_we_q    <= req_we_i;
                lat_addr_q  <= req_addr_i;
                lat_wdata_q <= req_wdata_i;
                lat_be_q    <= req_be_i;
            end
        end
    end

    data_ram_array #(
        .DEPTH_WORDS(DEPTH_WORDS),
        .IDX_W      (IDX_W)
    ) u_array (
        .clk  (clk),
        .en   (ram_en),
        .we   (ram_we),
        .addr (offset[IDX_W+1:2]),
        .wdata(cur_wdata),
        .rdata(ram_rdata)
    );

    assign req_ready_o = ready_q;
    assign rsp_valid_o = (state_q == StResp);
    assign rsp_rdata_o = zero_q ? 32'h0 : ram_rdata;
    assign rsp_err_o   = err_q;

    a_rsp_stable: assert property (@(posedge clk) disable iff (rst)
        rsp_valid_o && !rsp_ready_i |=> rsp_valid_o && $stable(rsp_rdata_o) && $stable(rsp_err_o));

    a_one_side: assert property (@(posedge clk) disable iff (rst)
        !(req_ready_o && rsp_valid_o));

endmodule
